// File: rtl/kernel_sequencer.sv
// rtl/kernel_sequencer.sv - job FIFO plus launch/wait/hold sequencer for one HLS kernel
// Optional forced completion in WAIT is enabled by defining KSEQ_TIMEOUT_EN.
module kernel_sequencer #(
  parameter int ARG_W   = 1,
  parameter int RES_W   = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [ARG_W-1:0] job_arg,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             res_timeout,
  output logic             k_r_enable,
  output logic [ARG_W-1:0] k_arg,
  input  logic             k_w_enable,
  input  logic [RES_W-1:0] k_result,
  output logic             busy,
  output logic [15:0]      jobs_done
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
  state_t state;

  logic [ARG_W-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             empty, full, push, pop;
  logic             w_prev, w_rise;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign job_ready = !full;
  assign push      = job_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign w_rise    = k_w_enable && !w_prev;
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= job_arg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // w_prev resets high so a done level held across reset is never seen as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_prev <= 1'b1;
    else        w_prev <= k_w_enable;
  end

`ifdef KSEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] t_cnt;
  logic          t_expired;
  logic          res_to_q;

  assign t_expired   = (t_cnt == TW'(TIMEOUT - 1));
  assign res_timeout = res_to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          t_cnt <= '0;
    else if (state == LAUNCH)            t_cnt <= '0;
    else if (state == WAIT && !t_expired) t_cnt <= t_cnt + 1'b1;
  end
`else
  assign res_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k_arg      <= '0;
      k_r_enable <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      jobs_done  <= '0;
`ifdef KSEQ_TIMEOUT_EN
      res_to_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            k_arg      <= mem[rd_ptr[PW-1:0]];
            k_r_enable <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          k_r_enable <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          // a real done edge wins over a simultaneous expiry
          if (w_rise) begin
            res_data  <= k_result;
            res_valid <= 1'b1;
            state     <= HOLD;
`ifdef KSEQ_TIMEOUT_EN
            res_to_q  <= 1'b0;
`endif
          end
`ifdef KSEQ_TIMEOUT_EN
          else if (t_expired) begin
            res_data  <= '0;
            res_to_q  <= 1'b1;
            res_valid <= 1'b1;
            state     <= HOLD;
          end
`endif
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            jobs_done <= jobs_done + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kernel_sequencer.sv
// tb/tb_kernel_sequencer.sv - randomized scoreboard bench for kernel_sequencer
// Timeout scenario runs only when KSEQ_TIMEOUT_EN is defined.
module tb_kernel_sequencer;
  localparam int ARG_W   = 1;
  localparam int RES_W   = 2;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic [ARG_W-1:0] job_arg = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [RES_W-1:0] res_data;
  logic             res_timeout;
  logic             k_r_enable;
  logic [ARG_W-1:0] k_arg;
  logic             k_w_enable = 1'b0;
  logic [RES_W-1:0] k_result = '0;
  logic             busy;
  logic [15:0]      jobs_done;

  kernel_sequencer #(.ARG_W(ARG_W), .RES_W(RES_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_arg(job_arg),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_timeout(res_timeout),
    .k_r_enable(k_r_enable), .k_arg(k_arg), .k_w_enable(k_w_enable), .k_result(k_result),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RES_W-1:0] data;
    logic             to;
  } exp_t;

  exp_t             exp_q [$];
  logic [ARG_W-1:0] arg_q [$];
  int               checks = 0;
  int               failures = 0;
  int               n_done = 0;
  bit               expect_timeout = 0;

  int               rr_mode = 1;
  int               lat_fixed = 0;
  bit               stuck_mode = 1;
  logic             stuck_w = 1'b1;
  logic [RES_W-1:0] stuck_res = '0;

  // Reference kernel: arg 1 -> 3, arg 0 -> 2
  function automatic logic [RES_W-1:0] kfun(input logic [ARG_W-1:0] a);
    return (a != 0) ? RES_W'(3) : RES_W'(2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Kernel behavioural model
  int               kcnt = 0;
  bit               kpend = 0;
  logic [ARG_W-1:0] karg = '0;
  always @(negedge clk) begin
    if (stuck_mode) begin
      k_w_enable = stuck_w;
      k_result   = stuck_res;
      kpend      = 0;
    end else if (k_r_enable) begin
      k_w_enable = 1'b0;
      kpend      = 1;
      kcnt       = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
      karg       = k_arg;
    end else if (kpend) begin
      kcnt--;
      if (kcnt <= 0) begin
        k_w_enable = 1'b1;
        k_result   = kfun(karg);
        kpend      = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard
  bit               prev_hold = 0, prev_ren = 0, inflight = 0;
  logic [RES_W-1:0] prev_data;
  logic             prev_to;
  exp_t             mon_e;
  logic [ARG_W-1:0] mon_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 0;
      prev_ren  = 0;
      inflight  = 0;
    end else begin
      if (job_valid && job_ready) begin
        mon_e.data = expect_timeout ? '0 : kfun(job_arg);
        mon_e.to   = expect_timeout;
        exp_q.push_back(mon_e);
        arg_q.push_back(job_arg);
      end
      if (k_r_enable) begin
        if (prev_ren) flag("r_enable_wider_than_one_cycle");
        if (inflight) flag("launch_while_result_pending");
        if (arg_q.size() == 0) flag("unexpected_launch");
        else begin
          mon_a = arg_q.pop_front();
          chk("k_arg", k_arg, mon_a);
        end
        inflight = 1;
      end
      prev_ren = k_r_enable;
      if (res_valid && prev_hold) begin
        chk("res_data_stable", res_data, prev_data);
        chk("res_timeout_stable", res_timeout, prev_to);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) flag("unexpected_result");
        else begin
          mon_e = exp_q.pop_front();
          chk("res_data", res_data, mon_e.data);
          chk("res_timeout", res_timeout, mon_e.to);
        end
        chk("jobs_done_at_handshake", jobs_done, 64'(n_done[15:0]));
        n_done++;
        inflight  = 0;
        prev_hold = 0;
      end else begin
        prev_hold = res_valid;
        prev_data = res_data;
        prev_to   = res_timeout;
      end
    end
  end

  task automatic push_job(input logic [ARG_W-1:0] a, input int max_wait, output bit ok);
    @(posedge clk); #1;
    job_valid = 1'b1;
    job_arg   = a;
    ok = 0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (job_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (!busy && !res_valid && exp_q.size() == 0 && arg_q.size() == 0) done = 1;
    end
    if (!done) flag("wait_idle_timeout");
  endtask

  task automatic wait_launch(input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (k_r_enable) seen = 1;
    end
    if (!seen) flag("wait_launch_timeout");
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_job_ready"}, job_ready, 1);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_timeout"}, res_timeout, 0);
    chk({tag, "_k_r_enable"}, k_r_enable, 0);
    chk({tag, "_k_arg"}, k_arg, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_jobs_done"}, jobs_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    int k;

    // Reset with done held high, then stuck-done scenario
    repeat (3) @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    push_job(1, 5, ok);
    if (!ok) flag("stuck_push");
    wait_launch(10);
    repeat (4) @(negedge clk);
    chk("stuck_no_result", res_valid, 0);
    stuck_w = 1'b0;
    repeat (2) @(negedge clk);
    stuck_res = 2'd3;
    stuck_w   = 1'b1;
    k = 0;
    while (!res_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("stuck_result_seen", res_valid, 1);
    wait_idle(50);
    stuck_mode = 0;

    // Single job with 5-cycle kernel latency
    lat_fixed = 5;
    push_job(1, 5, ok);
    if (!ok) flag("single_push");
    wait_idle(100);
    chk("single_jobs_done", jobs_done, 2);

    // Back-to-back 1, 0, 1
    lat_fixed = 0;
    push_job(1, 20, ok);
    push_job(0, 20, ok);
    push_job(1, 20, ok);
    wait_idle(200);
    chk("b2b_jobs_done", jobs_done, 5);
    chk("b2b_busy", busy, 0);

    // Full FIFO under result back-pressure
    rr_mode = 0;
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push_job(1'(i), 20, ok);
      if (ok) acc++;
    end
    @(negedge clk);
    chk("full_accepted", acc, DEPTH + 1);
    chk("full_job_ready", job_ready, 0);
    chk("full_busy", busy, 1);
    rr_mode = 1;
    push_job(1, 40, ok);
    chk("full_late_push", ok, 1);
    wait_idle(400);
    chk("full_jobs_done", jobs_done, 64'(n_done));

    // Randomized traffic
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      push_job(1'($urandom_range(0, 1)), 300, ok);
      if (!ok) flag("random_push_timeout");
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle(3000);
    chk("random_jobs_done", jobs_done, 64'(n_done));
    rr_mode = 1;

`ifdef KSEQ_TIMEOUT_EN
    stuck_mode = 1;
    stuck_w    = 1'b0;
    expect_timeout = 1;
    push_job(1, 5, ok);
    expect_timeout = 0;
    wait_launch(10);
    k = 0;
    while (!res_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", k, TIMEOUT + 1);
    wait_idle(50);
    stuck_mode = 0;
    push_job(0, 5, ok);
    wait_idle(100);
    chk("after_timeout_jobs_done", jobs_done, 64'(n_done));
`endif

    // Asynchronous reset while WAITing, with a second job queued
    lat_fixed = 40;
    push_job(1, 5, ok);
    wait_launch(10);
    push_job(1, 5, ok);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    exp_q.delete();
    arg_q.delete();
    n_done = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_reset_res_valid", res_valid, 0);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_jobs_done", jobs_done, 0);
    lat_fixed = 0;
    push_job(0, 5, ok);
    wait_idle(100);
    chk("post_reset_job_done", jobs_done, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kernel_sequencer.md
# kernel_sequencer

Job sequencer for a `main` kernel produced by the HLS flow. It queues argument words from a host-side valid/ready stream and starts the kernel with a one-cycle `r_enable` pulse. It then waits for the kernel's `w_enable` rising edge, captures `result`, and returns it on a valid/ready result stream. It sits between the host/testbench and one kernel instance, and replaces hand-driven `r_enable` stimulus.

## Interface
Parameters:
- `ARG_W`, 1, kernel argument width (`init_i`)
- `RES_W`, 2, kernel result width
- `DEPTH`, 4, job FIFO depth; power of 2, ≥2
- `TIMEOUT`, 1024, max cycles in WAIT before forced completion; ≥2

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `job_valid` in 1 / `job_ready` out 1 / `job_arg` in ARG_W: job input stream
- `res_valid` out 1 / `res_ready` in 1 / `res_data` out RES_W / `res_timeout` out 1: result stream
- `k_r_enable` out 1: kernel start pulse
- `k_arg` out ARG_W: kernel argument, to `init_i`
- `k_w_enable` in 1: kernel done
- `k_result` in RES_W: kernel result
- `busy` out 1: state ≠ IDLE or FIFO non-empty
- `jobs_done` out 16: completed-result count

## Operation
- Job FIFO: `DEPTH` entries; `job_ready = !full`. Push on `job_valid && job_ready`. No bypass: a pop while full does not raise `job_ready` in the same cycle.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head, register it into `k_arg`, and go to LAUNCH.
  - LAUNCH: `k_r_enable` = 1 for exactly this cycle, then go to WAIT. Clear the timeout counter.
  - WAIT: detect a rising edge of `k_w_enable` (`k_w_enable && !w_prev`). On an edge, `res_data <= k_result`, `res_timeout <= 0`, go to HOLD.
  - HOLD: `res_valid` = 1. On `res_ready`, `jobs_done` +1 (wraps at 2^16), go to IDLE.
- `w_prev` is registered every cycle in all states. It resets to 1, so a `k_w_enable` stuck high after reset never triggers completion.
- `k_arg` holds stable from the LAUNCH entry until the next pop.
- `res_data`/`res_timeout` hold stable while `res_valid` is high.
- Only one kernel job is in flight. No new launch occurs until the result handshake completes.
- Reset mid-operation: FIFO emptied, FSM → IDLE, all outputs return to reset values. The kernel itself is not reset by this block.
- Reset values: `job_ready` 1, `res_valid` 0, `res_data` 0, `res_timeout` 0, `k_r_enable` 0, `k_arg` 0, `busy` 0, `jobs_done` 0.

## Timing
- Job accepted at edge E0 into an empty FIFO with FSM in IDLE:
  - pop at E1, so `k_arg` is valid and `k_r_enable` is high from E1 to E2;
  - state is WAIT from E2.
- Done edge first sampled at edge En: `res_valid` high after En.
- Handshake at Em: `res_valid` low after Em. The next pop, if the FIFO is non-empty, is at Em+1.
- Per-job overhead is 3 cycles plus kernel latency plus host back-pressure.
- Push and pop may occur in the same cycle at any fill level except full (push blocked).

## Configuration
- `KSEQ_TIMEOUT_EN` defined:
  - WAIT counts cycles.
  - If the count reaches `TIMEOUT` with no done edge, go to HOLD with `res_data` = 0 and `res_timeout` = 1.
  - A done edge in the same cycle as expiry wins: normal result, `res_timeout` = 0.
- `KSEQ_TIMEOUT_EN` undefined:
  - No counter logic; WAIT waits indefinitely.
  - `res_timeout` is tied to 0.

## Test plan
- Single job: kernel model gives result 3 five cycles after start for arg 1. Push arg 1 → one `k_r_enable` pulse one cycle wide, `k_arg` = 1, `res_data` = 3, `res_timeout` = 0, `jobs_done` = 1.
- Back-to-back: push args 1, 0, 1 with `res_ready` = 1 (model: 0 → 2) → results 3, 2, 3 in order, three `r_enable` pulses, `jobs_done` = 3, `busy` low at the end.
- Full/back-pressure: `res_ready` = 0, push `DEPTH`+2 jobs → `job_ready` drops once the FIFO is full. Release `res_ready` → all accepted jobs complete in order, none lost or duplicated.
- Stuck done: hold `k_w_enable` = 1 through reset and the launch, then drop it and raise it at cycle 7 → exactly one result, captured at the cycle-7 edge.
- Timeout (with `KSEQ_TIMEOUT_EN`, `TIMEOUT` = 16): kernel never finishes → after 16 WAIT cycles `res_valid` = 1, `res_data` = 0, `res_timeout` = 1. The next job then runs normally.
- Reset mid-WAIT: assert `rst_n` low asynchronously mid-cycle → outputs return to reset values immediately, the FIFO is empty, and no result is produced.
